// File: rtl/exe_multiple_seq.sv
`default_nettype none
// exe_multiple_seq -- LDM/STM/PUSH/POP sequencer, one register beat per cycle, rev 1.0
// Optional macro MULTIPLE_DB_EN enables decrement-before addressing via mode_db.
module exe_multiple_seq #(
  parameter int NREG = 16,
  parameter int AW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     is_load,
  input  logic                     mode_db,
  input  logic                     wback,
  input  logic [AW-1:0]            base_addr,
  input  logic [3:0]               base_reg,
  input  logic [NREG-1:0]          reg_list,
  output logic                     busy,
  output logic                     done,
  output logic [AW-1:0]            mem_addr,
  output logic [$clog2(NREG)-1:0]  addr_i,
  output logic                     w_mem_en,
  output logic                     w_reg_en,
  output logic [3:0]               w_reg_addr,
  output logic                     wb_sel,
  output logic [AW-1:0]            wb_value
);
  localparam int IW = $clog2(NREG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t          state;
  logic [NREG-1:0] rem;
  logic [AW-1:0]   nxt_addr;
  logic            load_r;
  logic            wbdo_r;
  logic [3:0]      base_reg_r;

  logic [AW-1:0]   n4;
  logic [AW-1:0]   first_addr;
  logic [AW-1:0]   final_addr;
  logic            base_in_list;
  logic            wb_do;
  logic [NREG-1:0] src_list;
  logic [NREG-1:0] beat_rest;
  logic [IW-1:0]   beat_idx;
  logic [AW-1:0]   beat_addr;
  logic            beat_load;
  logic            beat_wbdo;
  logic            beat_go;

  // Byte span of the transfer (4 * popcount) and whether Rn is itself in the list.
  always_comb begin
    n4           = '0;
    base_in_list = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      n4 = n4 + AW'(reg_list[k]);
      if (base_reg == 4'(k)) base_in_list = base_in_list | reg_list[k];
    end
    n4 = n4 << 2;
  end

`ifdef MULTIPLE_DB_EN
  assign first_addr = mode_db ? (base_addr - n4) : base_addr;
  assign final_addr = mode_db ? (base_addr - n4) : (base_addr + n4);
`else
  logic unused_mode_db;
  assign unused_mode_db = mode_db;
  assign first_addr     = base_addr;
  assign final_addr     = base_addr + n4;
`endif

  // A loaded base register takes precedence over the writeback value.
  assign wb_do = wback & ~(is_load & base_in_list);

  // The first beat is issued from the live inputs on the start edge, later beats from latched state.
  always_comb begin
    src_list = (state == S_IDLE) ? reg_list : rem;
    beat_idx = '0;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (src_list[k]) beat_idx = IW'(k);
    end
    beat_rest = src_list & (src_list - NREG'(1));
    beat_addr = (state == S_IDLE) ? first_addr : nxt_addr;
    beat_load = (state == S_IDLE) ? is_load : load_r;
    beat_wbdo = (state == S_IDLE) ? wb_do : wbdo_r;
    beat_go   = (state == S_IDLE) ? (start && (reg_list != '0))
                                  : ((state == S_XFER) && (rem != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rem        <= '0;
      nxt_addr   <= '0;
      load_r     <= 1'b0;
      wbdo_r     <= 1'b0;
      base_reg_r <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_addr   <= '0;
      addr_i     <= '0;
      w_mem_en   <= 1'b0;
      w_reg_en   <= 1'b0;
      w_reg_addr <= '0;
      wb_sel     <= 1'b0;
      wb_value   <= '0;
    end else begin
      w_mem_en <= 1'b0;
      w_reg_en <= 1'b0;
      wb_sel   <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            load_r     <= is_load;
            wbdo_r     <= wb_do;
            base_reg_r <= base_reg;
            wb_value   <= final_addr;
            busy       <= 1'b1;
            if (reg_list != '0) begin
              state <= S_XFER;
            end else if (wb_do) begin
              w_reg_en   <= 1'b1;
              w_reg_addr <= base_reg;
              wb_sel     <= 1'b1;
              done       <= 1'b1;
              state      <= S_WB;
            end else begin
              // Empty list without writeback: a single idle busy cycle carrying done.
              rem   <= '0;
              done  <= 1'b1;
              state <= S_XFER;
            end
          end
        end
        S_XFER: begin
          if (rem == '0) begin
            if (wbdo_r) begin
              w_reg_en   <= 1'b1;
              w_reg_addr <= base_reg_r;
              wb_sel     <= 1'b1;
              done       <= 1'b1;
              state      <= S_WB;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_WB: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase

      if (beat_go) begin
        mem_addr <= beat_addr;
        addr_i   <= beat_idx;
        w_mem_en <= ~beat_load;
        w_reg_en <= beat_load;
        if (beat_load) w_reg_addr <= 4'(beat_idx);
        rem      <= beat_rest;
        nxt_addr <= beat_addr + AW'(4);
        done     <= (beat_rest == '0) && !beat_wbdo;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_multiple_seq.sv
`default_nettype none
// tb_exe_multiple_seq -- table-driven cycle vectors for exe_multiple_seq plus directed multi-cycle sequences.
module tb_exe_multiple_seq;
  localparam int NREG = 16;
  localparam int AW   = 32;
  localparam int IW   = 4;
  localparam int OW   = 77;

`ifdef MULTIPLE_DB_EN
  localparam logic [31:0] P_A1 = 32'h1F8, P_A2 = 32'h1FC, P_WB = 32'h1F8;
`else
  localparam logic [31:0] P_A1 = 32'h200, P_A2 = 32'h204, P_WB = 32'h208;
`endif

  logic            clk = 1'b0;
  logic            rst, start, is_load, mode_db, wback;
  logic [AW-1:0]   base_addr;
  logic [3:0]      base_reg;
  logic [NREG-1:0] reg_list;
  logic            busy, done, w_mem_en, w_reg_en, wb_sel;
  logic [AW-1:0]   mem_addr, wb_value;
  logic [IW-1:0]   addr_i;
  logic [3:0]      w_reg_addr;
  logic [OW-1:0]   act;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  exe_multiple_seq #(.NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .mode_db(mode_db),
    .wback(wback), .base_addr(base_addr), .base_reg(base_reg), .reg_list(reg_list),
    .busy(busy), .done(done), .mem_addr(mem_addr), .addr_i(addr_i),
    .w_mem_en(w_mem_en), .w_reg_en(w_reg_en), .w_reg_addr(w_reg_addr),
    .wb_sel(wb_sel), .wb_value(wb_value)
  );

  assign act = {busy, done, mem_addr, addr_i, w_mem_en, w_reg_en, w_reg_addr, wb_sel, wb_value};

  typedef struct packed {
    logic          r;
    logic          s;
    logic          ld;
    logic          db;
    logic          wb;
    logic [31:0]   ba;
    logic [3:0]    br;
    logic [15:0]   rl;
    logic [OW-1:0] e;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [OW-1:0] o(logic b, logic d, logic [31:0] ma, logic [3:0] ai,
                                      logic me, logic re, logic [3:0] ra, logic s, logic [31:0] wv);
    return {b, d, ma, ai, me, re, ra, s, wv};
  endfunction

  function automatic vec_t v(logic r, logic s, logic ld, logic db, logic wb,
                             logic [31:0] ba, logic [3:0] br, logic [15:0] rl, logic [OW-1:0] e);
    vec_t x;
    x.r = r; x.s = s; x.ld = ld; x.db = db; x.wb = wb;
    x.ba = ba; x.br = br; x.rl = rl; x.e = e;
    return x;
  endfunction

  function automatic vec_t st(logic ld, logic db, logic wb, logic [31:0] ba, logic [3:0] br,
                              logic [15:0] rl, logic [OW-1:0] e);
    return v(1'b0, 1'b1, ld, db, wb, ba, br, rl, e);
  endfunction

  function automatic vec_t nop(logic [OW-1:0] e);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 16'h0, e);
  endfunction

  task automatic drive(input vec_t x);
    rst = x.r; start = x.s; is_load = x.ld; mode_db = x.db; wback = x.wb;
    base_addr = x.ba; base_reg = x.br; reg_list = x.rl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [OW-1:0] a, input logic [OW-1:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, a, e);
    end
  endtask

  initial begin
    logic [35:0] beat_rec [3];
    int          beats;
    logic        seen_done;
    logic [OW-1:0] acc;

    // Reset, start-with-reset, store IA with writeback
    tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,   4'd0,  16'h0,    o(0,0,32'h0,0,0,0,0,0,32'h0)));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h100, 4'd13, 16'h0013, o(0,0,32'h0,0,0,0,0,0,32'h0)));
    tbl.push_back(nop(o(0,0,32'h0,0,0,0,0,0,32'h0)));
    tbl.push_back(st(0, 0, 1, 32'h100, 4'd13, 16'h0013, o(1,0,32'h100,0,1,0,0,0,32'h10C)));
    tbl.push_back(nop(o(1,0,32'h104,1,1,0,0,0,32'h10C)));
    tbl.push_back(nop(o(1,0,32'h108,4,1,0,0,0,32'h10C)));
    tbl.push_back(nop(o(1,1,32'h108,4,0,1,13,1,32'h10C)));
    tbl.push_back(nop(o(0,0,32'h108,4,0,0,13,0,32'h10C)));
    // Load with base in list: no WB
    tbl.push_back(st(1, 0, 1, 32'h300, 4'd2, 16'h0006, o(1,0,32'h300,1,0,1,1,0,32'h308)));
    tbl.push_back(nop(o(1,1,32'h304,2,0,1,2,0,32'h308)));
    tbl.push_back(nop(o(0,0,32'h304,2,0,0,2,0,32'h308)));
    // Empty list, no writeback; start while busy ignored
    tbl.push_back(st(0, 0, 0, 32'h400, 4'd7, 16'h0000, o(1,1,32'h304,2,0,0,2,0,32'h400)));
    tbl.push_back(st(0, 0, 0, 32'h500, 4'd7, 16'h0001, o(0,0,32'h304,2,0,0,2,0,32'h400)));
    tbl.push_back(nop(o(0,0,32'h304,2,0,0,2,0,32'h400)));
    // Reset after second of four beats, then address wrap
    tbl.push_back(st(0, 0, 0, 32'h1000, 4'd0, 16'h000F, o(1,0,32'h1000,0,1,0,2,0,32'h1010)));
    tbl.push_back(nop(o(1,0,32'h1004,1,1,0,2,0,32'h1010)));
    tbl.push_back(v(1, 0, 0, 0, 0, 32'h0, 4'd0, 16'h0, o(0,0,32'h0,0,0,0,0,0,32'h0)));
    tbl.push_back(nop(o(0,0,32'h0,0,0,0,0,0,32'h0)));
    tbl.push_back(st(0, 0, 0, 32'hFFFFFFFC, 4'd0, 16'h0003, o(1,0,32'hFFFFFFFC,0,1,0,0,0,32'h4)));
    tbl.push_back(nop(o(1,1,32'h0,1,1,0,0,0,32'h4)));
    tbl.push_back(nop(o(0,0,32'h0,1,0,0,0,0,32'h4)));
    // Push with mode_db=1 (IA when the DB option is compiled out)
    tbl.push_back(st(0, 1, 1, 32'h200, 4'd13, 16'h4010, o(1,0,P_A1,4,1,0,0,0,P_WB)));
    tbl.push_back(nop(o(1,0,P_A2,14,1,0,0,0,P_WB)));
    tbl.push_back(nop(o(1,1,P_A2,14,0,1,13,1,P_WB)));
    tbl.push_back(nop(o(0,0,P_A2,14,0,0,13,0,P_WB)));
    // Empty list with writeback
    tbl.push_back(st(1, 0, 1, 32'h700, 4'd3, 16'h0000, o(1,1,P_A2,14,0,1,3,1,32'h700)));
    tbl.push_back(nop(o(0,0,P_A2,14,0,0,3,0,32'h700)));
    // Single-register load of r15 followed by WB
    tbl.push_back(st(1, 0, 1, 32'h800, 4'd0, 16'h8000, o(1,0,32'h800,15,0,1,15,0,32'h804)));
    tbl.push_back(nop(o(1,1,32'h800,15,0,1,0,1,32'h804)));
    tbl.push_back(nop(o(0,0,32'h800,15,0,0,0,0,32'h804)));

    drive(tbl[0]);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      step();
      chk($sformatf("vec%0d", i), act, tbl[i].e);
    end

    // start held high through a three-beat store must not restart or alter it
    drive(st(0, 0, 0, 32'h40, 4'd1, 16'h0007, '0));
    beats     = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 8 && !seen_done; c++) begin
      step();
      reg_list = 16'hFF00;
      if (w_mem_en) begin
        if (beats < 3) beat_rec[beats] = {mem_addr, addr_i};
        beats++;
      end
      if (done) begin
        seen_done = 1'b1;
        start     = 1'b0;
      end
    end
    chk("busy_start_done_seen", OW'(seen_done), OW'(1'b1));
    chk("busy_start_beats", OW'(beats), OW'(3));
    chk("busy_start_beat0", OW'(beat_rec[0]), OW'({32'h40, 4'd0}));
    chk("busy_start_beat1", OW'(beat_rec[1]), OW'({32'h44, 4'd1}));
    chk("busy_start_beat2", OW'(beat_rec[2]), OW'({32'h48, 4'd2}));
    step();
    chk("busy_start_idle", OW'({busy, done, w_mem_en, w_reg_en}), OW'(4'b0000));

    // Reset on the WB cycle, then no enables until a new start
    drive(st(0, 0, 1, 32'h10, 4'd9, 16'h0001, '0));
    step();
    chk("rst_wb_beat", OW'({busy, done, w_mem_en, w_reg_en, wb_sel, mem_addr}), OW'({5'b10100, 32'h10}));
    start = 1'b0;
    step();
    chk("rst_wb_cycle", OW'({busy, done, w_reg_en, wb_sel, w_reg_addr, wb_value}),
        OW'({4'b1111, 4'd9, 32'h14}));
    rst   = 1'b1;
    start = 1'b1;
    step();
    chk("rst_wb_zero", act, '0);
    rst   = 1'b0;
    start = 1'b0;
    acc   = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      acc = acc | act;
    end
    chk("rst_wb_quiet", acc, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
